// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches 8-bit words from ROM over req/ack
// and presents opcode/immediate to decode. Optional halt on opcode F via FETCH_HALT_EN.
module fetch_unit #(
  parameter int PC_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PC_WIDTH-1:0] rom_addr,
  output logic                rom_req,
  input  logic                rom_ack,
  input  logic [7:0]          rom_data,
  input  logic                stall,
  input  logic                jump_en,
  input  logic [PC_WIDTH-1:0] jump_addr,
  output logic [3:0]          op_out,
  output logic [3:0]          imm_out,
  output logic                insn_valid,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
`ifdef FETCH_HALT_EN
    S_ISSUE,
    S_HALT
`else
    S_ISSUE
`endif
  } state_t;

  state_t              state_reg;
  logic [PC_WIDTH-1:0] pc_reg;
  logic [7:0]          ir_reg;
  logic                rom_req_reg;
  logic                insn_valid_reg;
`ifdef FETCH_HALT_EN
  logic                halted_reg;
`endif

  // Handshake flags are registered alongside the state so outputs never see inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      pc_reg         <= '0;
      ir_reg         <= 8'h00;
      rom_req_reg    <= 1'b0;
      insn_valid_reg <= 1'b0;
`ifdef FETCH_HALT_EN
      halted_reg     <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          state_reg   <= S_FETCH;
          rom_req_reg <= 1'b1;
        end
        S_FETCH: begin
          if (rom_ack) begin
            ir_reg         <= rom_data;
            state_reg      <= S_ISSUE;
            rom_req_reg    <= 1'b0;
            insn_valid_reg <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            insn_valid_reg <= 1'b0;
`ifdef FETCH_HALT_EN
            if (ir_reg[7:4] == 4'hF) begin
              state_reg  <= S_HALT;
              halted_reg <= 1'b1;
            end else begin
              pc_reg      <= jump_en ? jump_addr : pc_reg + PC_WIDTH'(1);
              state_reg   <= S_FETCH;
              rom_req_reg <= 1'b1;
            end
`else
            pc_reg      <= jump_en ? jump_addr : pc_reg + PC_WIDTH'(1);
            state_reg   <= S_FETCH;
            rom_req_reg <= 1'b1;
`endif
          end
        end
`ifdef FETCH_HALT_EN
        S_HALT: begin
          state_reg <= S_HALT;
        end
`endif
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign rom_addr   = pc_reg;
  assign pc_out     = pc_reg;
  assign rom_req    = rom_req_reg;
  assign insn_valid = insn_valid_reg;
  assign op_out     = ir_reg[7:4];
  assign imm_out    = ir_reg[3:0];
`ifdef FETCH_HALT_EN
  assign halted     = halted_reg;
`else
  assign halted     = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the FourBitCPU, sitting directly upstream of the instruction decoder. Holds the program counter and requests 8-bit instruction words from program ROM over a req/ack handshake. Splits each word into a 4-bit opcode, which drives the decoder's `op_in`, and a 4-bit immediate for the ALU. Presents each instruction for at least one cycle, honours a stall from the execute side, and accepts jump targets.

## Interface
Parameters:
- `PC_WIDTH`, default 4: program counter and ROM address width.

Ports:
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rom_addr`  out  PC_WIDTH: ROM word address; equals `pc`.
- `rom_req`  out  1: fetch request.
- `rom_ack`  in  1: ROM data valid this cycle.
- `rom_data`  in  8: instruction word; [7:4] opcode, [3:0] immediate.
- `stall`  in  1: execute stage cannot accept; hold the current instruction.
- `jump_en`  in  1: load `jump_addr` as next PC.
- `jump_addr`  in  PC_WIDTH: jump target.
- `op_out`  out  4: opcode to decoder `op_in`.
- `imm_out`  out  4: immediate to ALU.
- `insn_valid`  out  1: `op_out`/`imm_out` hold a live instruction.
- `pc_out`  out  PC_WIDTH: address of the instruction on `op_out`.
- `halted`  out  1: core stopped (see Configuration).

## Operation
- Registers: `pc`, 8-bit instruction register `ir`, state.
- `op_out` = `ir[7:4]`. `imm_out` = `ir[3:0]`. `pc_out` = `rom_addr` = `pc`.
- States:
  - IDLE: reset state. Unconditionally moves to FETCH on the next edge.
  - FETCH: `rom_req`=1.
    - On an edge with `rom_ack`=1: `ir` <= `rom_data`; go to ISSUE.
    - Otherwise stay in FETCH with `rom_addr` held stable.
  - ISSUE: `insn_valid`=1.
    - `stall`=1: stay in ISSUE; `ir` and `pc` hold; `jump_en` is ignored.
    - `stall`=0: `pc` <= `jump_en` ? `jump_addr` : `pc`+1, modulo 2^PC_WIDTH so the maximum address wraps to 0; go to FETCH.
  - HALT: only present with `FETCH_HALT_EN`.
- Ignored inputs:
  - `rom_ack` outside FETCH.
  - `jump_en` outside an unstalled ISSUE cycle.
- Outputs are decoded from registered state only. There are no combinational paths from inputs to outputs.
- Reset values:
  - `pc`=0, `ir`=8'h00 (OP_NOP, imm 0), state IDLE.
  - `rom_req`=0, `insn_valid`=0, `halted`=0, `op_out`=0, `imm_out`=0, `pc_out`=0, `rom_addr`=0.
- Reset asserted mid-fetch or mid-issue: all of the above take effect immediately (asynchronously). A pending ROM transaction is abandoned; the ROM must tolerate `rom_req` dropping before ack.

## Timing
- Reset release at edge 0:
  - IDLE during cycle 0–1.
  - `rom_req`=1 from the cycle after the first edge.
- Ack latency: `rom_ack` sampled high at edge N gives `insn_valid`=1 and new `op_out` from edge N until the leaving edge.
- Unstalled ISSUE at edge M: `rom_req`=1 with the new `rom_addr` from edge M.
- Best-case throughput: ack in the first FETCH cycle gives 1 instruction per 2 cycles.
- Each stall cycle extends ISSUE by exactly one cycle.

## Configuration
- `FETCH_HALT_EN` defined:
  - An unstalled ISSUE cycle with opcode 4'hF enters HALT instead of FETCH; `pc` is not advanced.
  - In HALT: `halted`=1, `rom_req`=0, `insn_valid`=0, and `pc`/`ir` frozen.
  - Only reset exits HALT.
- `FETCH_HALT_EN` not defined:
  - HALT state and related logic are absent; `halted` is tied to 0.
  - Opcode 4'hF issues like any other opcode (the decoder treats it as NOP).

## Test plan
- ROM ack same cycle as req, rom[0]=8'h15, rom[1]=8'h2A -> `op_out`=1/`imm_out`=5 then 2/A; `insn_valid` high one cycle each, 2 cycles apart; `pc_out` 0 then 1.
- `rom_ack` delayed 3 cycles at addr 0 -> `rom_req` high and `rom_addr`=0 for 4 cycles; `insn_valid` rises on the edge after ack.
- `stall`=1 for 2 cycles during ISSUE of addr 2, with `jump_en` pulsed during the stall -> `insn_valid` high 3 cycles, `rom_req` low throughout, jump ignored, next `rom_addr`=3.
- Unstalled ISSUE at addr 5 with `jump_en`=1, `jump_addr`=4'hA -> next `rom_addr`=A. Run from pc=F with no jump -> next `rom_addr`=0.
- `rst_n` asserted during FETCH with ack pending -> `rom_req`, `insn_valid`, `pc` go to 0 without a clock edge. After release, the fetch restarts at addr 0.
- rom[3]=8'hF0:
  - With `FETCH_HALT_EN`: `halted`=1 after ISSUE of addr 3, no further `rom_req`, `pc_out` stays 3.
  - Without it: fetch continues at addr 4, `halted`=0.
